spc700_ram_loader: RTL and testbench

SPC700_RAM_LOADER -- requirements
Module: spc700_ram_loader

---
 rtl/spc700_pkg.sv | 19 +
 rtl/spc700_ram_loader.sv | 140 ++++++++++++++
 tb/tb_spc700_ram_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spc700_pkg.sv
// Shared constants and state encoding for the SPC700 RAM loader.
package spc700_pkg;

    localparam logic [7:0] OPC_WRITE = 8'h01;
    localparam logic [7:0] OPC_READ  = 8'h02;

    localparam int unsigned LEN_BITS     = 16;
    localparam int unsigned HDR_CNT_BITS = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RREQ  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RSEND = 3'd5
    } state_t;

endpackage

// File: rtl/spc700_ram_loader.sv
// Host-side byte-stream loader: frames of opcode + 16-bit address + 16-bit length
// drive writes into, or reads back from, the SPC700 RAM control port.
module spc700_ram_loader
    import spc700_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              in_cmd_data,
    input  logic                    in_cmd_valid,
    output logic                    out_cmd_ready,
    output logic [7:0]              out_rsp_data,
    output logic                    out_rsp_valid,
    input  logic                    in_rsp_ready,
    output logic [ADDRESS_BITS-1:0] out_ctrl_address,
    output logic [7:0]              out_ctrl_data,
    input  logic [7:0]              in_ctrl_data,
    output logic                    out_ctrl_we,
    output logic                    out_busy
);

    state_t                  r_state;
    logic [HDR_CNT_BITS-1:0] r_hdr_cnt;
    logic                    r_is_read;
    logic [7:0]              r_addr_hi;
    logic [7:0]              r_len_hi;
    logic [ADDRESS_BITS-1:0] r_addr;
    logic [LEN_BITS-1:0]     r_remain;
    logic [ADDRESS_BITS-1:0] r_ctrl_addr;
    logic [7:0]              r_ctrl_data;
    logic                    r_ctrl_we;
    logic [7:0]              r_rsp_data;
    logic                    r_rsp_valid;

    logic                    w_cmd_fire;
    logic [ADDRESS_BITS-1:0] w_addr_next;

    // Command stream is open only while the loader is taking header or write bytes.
    assign out_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_HDR) || (r_state == ST_WDATA);
    assign out_busy      = (r_state != ST_IDLE);
    assign w_cmd_fire    = in_cmd_valid && out_cmd_ready;
    assign w_addr_next   = r_addr + ADDRESS_BITS'(1);

    assign out_ctrl_address = r_ctrl_addr;
    assign out_ctrl_data    = r_ctrl_data;
    assign out_ctrl_we      = r_ctrl_we;
    assign out_rsp_data     = r_rsp_data;
    assign out_rsp_valid    = r_rsp_valid;

    // Frame sequencer; r_remain holds (bytes left - 1), so 0 marks the last byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hdr_cnt   <= '0;
            r_is_read   <= 1'b0;
            r_addr_hi   <= '0;
            r_len_hi    <= '0;
            r_addr      <= '0;
            r_remain    <= '0;
            r_ctrl_addr <= '0;
            r_ctrl_data <= '0;
            r_ctrl_we   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_ctrl_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_hdr_cnt <= '0;
                        if (in_cmd_data == OPC_WRITE) begin
                            r_is_read <= 1'b0;
                            r_state   <= ST_HDR;
                        end else if (in_cmd_data == OPC_READ) begin
                            r_is_read <= 1'b1;
                            r_state   <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (w_cmd_fire) begin
                        r_hdr_cnt <= r_hdr_cnt + HDR_CNT_BITS'(1);
                        case (r_hdr_cnt)
                            2'd0: r_addr_hi <= in_cmd_data;
                            2'd1: r_addr    <= ADDRESS_BITS'({r_addr_hi, in_cmd_data});
                            2'd2: r_len_hi  <= in_cmd_data;
                            2'd3: begin
                                r_remain <= {r_len_hi, in_cmd_data};
                                if (r_is_read) begin
                                    r_ctrl_addr <= r_addr;
                                    r_state     <= ST_RREQ;
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end
                            default: r_addr_hi <= r_addr_hi;
                        endcase
                    end
                end
                ST_WDATA: begin
                    if (w_cmd_fire) begin
                        r_ctrl_addr <= r_addr;
                        r_ctrl_data <= in_cmd_data;
                        r_ctrl_we   <= 1'b1;
                        r_addr      <= w_addr_next;
                        if (r_remain == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_remain <= r_remain - LEN_BITS'(1);
                        end
                    end
                end
                ST_RREQ: begin
                    r_state <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    r_rsp_data  <= in_ctrl_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RSEND;
                end
                ST_RSEND: begin
                    if (in_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_remain == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_remain    <= r_remain - LEN_BITS'(1);
                            r_addr      <= w_addr_next;
                            r_ctrl_addr <= w_addr_next;
                            r_state     <= ST_RREQ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spc700_ram_loader.sv
// Directed bench for spc700_ram_loader with a byte-array RAM and a frame-level reference model.
module tb_spc700_ram_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_cmd_data = 8'h00;
    logic        in_cmd_valid = 1'b0;
    logic        out_cmd_ready;
    logic [7:0]  out_rsp_data;
    logic        out_rsp_valid;
    logic        in_rsp_ready = 1'b0;
    logic [15:0] out_ctrl_address;
    logic [7:0]  out_ctrl_data;
    logic [7:0]  in_ctrl_data = 8'h00;
    logic        out_ctrl_we;
    logic        out_busy;

    spc700_ram_loader #(.ADDRESS_BITS(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_cmd_data     (in_cmd_data),
        .in_cmd_valid    (in_cmd_valid),
        .out_cmd_ready   (out_cmd_ready),
        .out_rsp_data    (out_rsp_data),
        .out_rsp_valid   (out_rsp_valid),
        .in_rsp_ready    (in_rsp_ready),
        .out_ctrl_address(out_ctrl_address),
        .out_ctrl_data   (out_ctrl_data),
        .in_ctrl_data    (in_ctrl_data),
        .out_ctrl_we     (out_ctrl_we),
        .out_busy        (out_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM attached to the control port: synchronous write, one-cycle read latency
    logic [7:0] mem [0:65535] = '{default: 8'h00};
    always @(posedge clock) begin
        if (out_ctrl_we) mem[out_ctrl_address] <= out_ctrl_data;
        in_ctrl_data <= mem[out_ctrl_address];
    end

    // Reference model: expected RAM contents and expected transactions
    logic [7:0]  ref_mem [0:65535] = '{default: 8'h00};
    logic [23:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [23:0] wr_log[$];
    logic [7:0]  rd_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rate_frame = 0;
    logic in_read = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Per-cycle compare against the model
    int          prev_cyc   = -1;
    int          prev_frame = -1;
    logic        prev_hold  = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    logic [15:0] prev_addr  = 16'h0000;
    always @(negedge clock) begin
        if (out_ctrl_we === 1'b1) begin
            if (exp_wr.size() == 0) flag_fail("unexpected_write");
            else check("ctrl_write", {8'h00, out_ctrl_address, out_ctrl_data}, {8'h00, exp_wr.pop_front()});
            wr_log.push_back({out_ctrl_address, out_ctrl_data});
        end
        if (!reset) begin
            if (out_rsp_valid && in_rsp_ready) begin
                if (exp_rd.size() == 0) flag_fail("unexpected_rsp");
                else check("rsp_data", {24'h0, out_rsp_data}, {24'h0, exp_rd.pop_front()});
                rd_log.push_back(out_rsp_data);
                if (prev_frame == rate_frame) check("rsp_rate", cyc - prev_cyc, 3);
                prev_cyc   = cyc;
                prev_frame = rate_frame;
            end
            if (prev_hold) begin
                check("rsp_hold_valid", {31'h0, out_rsp_valid}, 1);
                check("rsp_hold_data", {24'h0, out_rsp_data}, {24'h0, prev_data});
                check("rsp_hold_addr", {16'h0, out_ctrl_address}, {16'h0, prev_addr});
            end
            prev_hold = out_rsp_valid && !in_rsp_ready;
            prev_data = out_rsp_data;
            prev_addr = out_ctrl_address;
            if (in_read) check("cmd_ready_in_read", {31'h0, out_cmd_ready}, 0);
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Offer one byte; called #1 after a rising edge, returns #1 after the transfer edge
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_cmd_data  = b;
        in_cmd_valid = 1'b1;
        while (!out_cmd_ready && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        if (!out_cmd_ready) flag_fail("cmd_ready_timeout");
        @(posedge clock); #1;
        in_cmd_valid = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
        ref_mem[a] = d;
    endtask

    task automatic send_write(input logic [15:0] addr, input logic [7:0] d[$]);
        logic [15:0] len = 16'(d.size() - 1);
        for (int i = 0; i < d.size(); i++) model_write(addr + 16'(i), d[i]);
        send_byte(8'h01);
        send_byte(addr[15:8]); send_byte(addr[7:0]);
        send_byte(len[15:8]);  send_byte(len[7:0]);
        for (int i = 0; i < d.size(); i++) send_byte(d[i]);
    endtask

    task automatic send_read(input logic [15:0] addr, input int n, input int hold);
        logic [15:0] len = 16'(n - 1);
        int t = 0;
        for (int i = 0; i < n; i++) exp_rd.push_back(ref_mem[addr + 16'(i)]);
        in_rsp_ready = (hold == 0);
        rate_frame++;
        send_byte(8'h02);
        send_byte(addr[15:8]); send_byte(addr[7:0]);
        send_byte(len[15:8]);  send_byte(len[7:0]);
        in_read = 1'b1;
        repeat (hold) begin @(posedge clock); #1; end
        in_rsp_ready = 1'b1;
        while (exp_rd.size() != 0 && t < 300) begin
            @(posedge clock);
            t++;
        end
        #1;
        in_read = 1'b0;
        if (exp_rd.size() != 0) flag_fail("read_drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [7:0] d[$];

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'h0, out_busy}, 0);
        check("rst_we", {31'h0, out_ctrl_we}, 0);
        check("rst_rsp_valid", {31'h0, out_rsp_valid}, 0);
        check("rst_addr", {16'h0, out_ctrl_address}, 0);
        check("rst_wdata", {24'h0, out_ctrl_data}, 0);
        check("rst_rsp_data", {24'h0, out_rsp_data}, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_cmd_ready", {31'h0, out_cmd_ready}, 1);

        // Plain write of three bytes
        d = '{8'hAA, 8'hBB, 8'hCC};
        send_write(16'h1234, d);
        check("w1_busy_after", {31'h0, out_busy}, 0);
        repeat (2) @(posedge clock); #1;
        check("w1_log_size", wr_log.size(), 3);
        check("w1_lit0", {8'h0, wr_log[0]}, 32'h001234AA);
        check("w1_lit1", {8'h0, wr_log[1]}, 32'h001235BB);
        check("w1_lit2", {8'h0, wr_log[2]}, 32'h001236CC);

        // Read them back at full rate
        send_read(16'h1234, 3, 0);
        check("r1_log_size", rd_log.size(), 3);
        check("r1_lit0", {24'h0, rd_log[0]}, 32'hAA);
        check("r1_lit1", {24'h0, rd_log[1]}, 32'hBB);
        check("r1_lit2", {24'h0, rd_log[2]}, 32'hCC);
        check("r1_busy_after", {31'h0, out_busy}, 0);

        // Address wrap at the top of RAM
        d = '{8'h11, 8'h22};
        send_write(16'hFFFF, d);
        repeat (2) @(posedge clock); #1;
        check("wrap_lit0", {8'h0, wr_log[3]}, 32'h00FFFF11);
        check("wrap_lit1", {8'h0, wr_log[4]}, 32'h00000022);

        // Read with the host stalling the response for 10 cycles
        send_read(16'hFFFF, 2, 10);
        check("stall_lit0", {24'h0, rd_log[3]}, 32'h11);
        check("stall_lit1", {24'h0, rd_log[4]}, 32'h22);

        // Unknown opcode dropped, then a one-byte write
        send_byte(8'h7F);
        check("drop_busy", {31'h0, out_busy}, 0);
        d = '{8'h55};
        send_write(16'h0000, d);
        repeat (2) @(posedge clock); #1;
        check("drop_lit", {8'h0, wr_log[5]}, 32'h00000055);

        // Reset after the second of three data bytes
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h00); send_byte(8'h02);
        model_write(16'h0020, 8'hD1);
        model_write(16'h0021, 8'hD2);
        send_byte(8'hD1);
        send_byte(8'hD2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_busy", {31'h0, out_busy}, 0);
        check("mid_rst_we", {31'h0, out_ctrl_we}, 0);
        check("mid_rst_ready", {31'h0, out_cmd_ready}, 1);
        repeat (3) @(posedge clock); #1;
        check("mid_rst_writes", wr_log.size(), 8);
        check("mid_rst_lit", {8'h0, wr_log[7]}, 32'h000021D2);

        // New frame with data bytes that look like opcodes
        d = '{8'h02, 8'h01};
        send_write(16'h0030, d);
        check("pos_busy_after", {31'h0, out_busy}, 0);
        send_read(16'h0020, 3, 0);
        check("mid_rd_lit0", {24'h0, rd_log[5]}, 32'hD1);
        check("mid_rd_lit1", {24'h0, rd_log[6]}, 32'hD2);
        check("mid_rd_lit2", {24'h0, rd_log[7]}, 32'h00);
        send_read(16'h0030, 2, 0);
        check("pos_rd_lit0", {24'h0, rd_log[8]}, 32'h02);
        check("pos_rd_lit1", {24'h0, rd_log[9]}, 32'h01);

        repeat (4) @(posedge clock); #1;
        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_rd_drained", exp_rd.size(), 0);
        check("final_busy", {31'h0, out_busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
